// File: rtl/bitonic_network_16_pkg.sv
// bitonic_network_16_pkg: shared widths, latency and element helpers for the 16-input bitonic merger.
package bitonic_network_16_pkg;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_KEY_WIDTH  = 80;
    localparam int LATENCY        = 4;
    localparam int N_ELEMS        = 16;

    function automatic logic [DEF_KEY_WIDTH-1:0] key_of(input logic [DEF_DATA_WIDTH-1:0] e);
        return e[DEF_KEY_WIDTH-1:0];
    endfunction

    function automatic logic [DEF_DATA_WIDTH-1:0] elem_at(input logic [8*DEF_DATA_WIDTH-1:0] v, input int i);
        return v[i*DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
    endfunction
endpackage

// File: rtl/bitonic_network_16_cas.sv
// bitonic_cas: combinational compare-and-swap; the smaller key goes low, equal keys stay in place.
module bitonic_cas
    import bitonic_network_16_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEY_WIDTH  = DEF_KEY_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] lo_o,
    output logic [DATA_WIDTH-1:0] hi_o
);
    logic swap;
    always_comb begin
        swap = b_i[KEY_WIDTH-1:0] < a_i[KEY_WIDTH-1:0];
        lo_o = swap ? b_i : a_i;
        hi_o = swap ? a_i : b_i;
    end
endmodule

// File: rtl/bitonic_network_16.sv
// bitonic_network_16: 4-stage pipelined merge of two ascending 8-element blocks into 16 ascending elements.
module bitonic_network_16
    import bitonic_network_16_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEY_WIDTH  = DEF_KEY_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    switch_output,
    input  logic                    stall,
    input  logic [8*DATA_WIDTH-1:0] top_tuple,
    input  logic [8*DATA_WIDTH-1:0] i_elems_0,
    input  logic [8*DATA_WIDTH-1:0] i_elems_1,
    output logic [8*DATA_WIDTH-1:0] o_elems_0,
    output logic [8*DATA_WIDTH-1:0] o_elems_1,
    output logic                    o_switch_output,
    output logic                    o_stall,
    output logic [8*DATA_WIDTH-1:0] o_top_tuple
);
    localparam int DW = DATA_WIDTH;
    localparam int BW = 8 * DW;

    logic [N_ELEMS*DW-1:0] net_in;
    logic [N_ELEMS*DW-1:0] stage_d [LATENCY];
    logic [N_ELEMS*DW-1:0] stage_q [LATENCY];
    logic [BW-1:0]         tt_q    [LATENCY];
    logic [LATENCY-1:0]    sw_q;
    logic [LATENCY-1:0]    stall_q;

    // Block B enters reversed so A ++ rev(B) forms a bitonic sequence
    assign net_in[BW-1:0] = i_elems_0;
    for (genvar r = 0; r < 8; r++) begin : g_rev
        assign net_in[(8+r)*DW +: DW] = i_elems_1[(7-r)*DW +: DW];
    end

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        localparam int D = 8 >> s;
        logic [N_ELEMS*DW-1:0] src;
        logic [N_ELEMS*DW-1:0] nxt;
        if (s == 0) begin : g_first
            assign src = net_in;
        end else begin : g_next
            assign src = stage_q[s-1];
        end
        for (genvar c = 0; c < 8; c++) begin : g_cas
            localparam int LO = (c / D) * 2 * D + c % D;
            bitonic_cas #(
                .DATA_WIDTH(DW),
                .KEY_WIDTH (KEY_WIDTH)
            ) u_cas (
                .a_i (src[LO*DW +: DW]),
                .b_i (src[(LO+D)*DW +: DW]),
                .lo_o(nxt[LO*DW +: DW]),
                .hi_o(nxt[(LO+D)*DW +: DW])
            );
        end
        assign stage_d[s] = nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_q[k] <= '0;
                tt_q[k]    <= '0;
            end
            sw_q    <= '0;
            stall_q <= '1;
        end else begin
            for (int k = 0; k < LATENCY; k++) stage_q[k] <= stage_d[k];
            tt_q[0] <= top_tuple;
            for (int k = 1; k < LATENCY; k++) tt_q[k] <= tt_q[k-1];
            sw_q    <= {sw_q[LATENCY-2:0], switch_output};
            stall_q <= {stall_q[LATENCY-2:0], stall};
        end
    end

    assign o_elems_0       = stage_q[LATENCY-1][BW-1:0];
    assign o_elems_1       = stage_q[LATENCY-1][2*BW-1:BW];
    assign o_top_tuple     = tt_q[LATENCY-1];
    assign o_switch_output = sw_q[LATENCY-1];
    assign o_stall         = stall_q[LATENCY-1];
endmodule

// File: tb/tb_bitonic_network_16.sv
// tb_bitonic_network_16: scoreboard bench comparing each output beat against a sorted reference merge.
module tb_bitonic_network_16;
    import bitonic_network_16_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int KW = DEF_KEY_WIDTH;
    localparam int BW = 8 * DW;

    typedef logic [DW-1:0] elem_t;
    typedef logic [BW-1:0] blk_t;
    typedef struct {
        blk_t e0;
        blk_t e1;
        blk_t tt;
        logic sw;
        logic st;
        logic tie;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw  = 1'b0;
    logic st  = 1'b1;
    blk_t tt  = '0;
    blk_t a   = '0;
    blk_t b   = '0;
    blk_t o0, o1, ott;
    logic osw, ost;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitonic_network_16 dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .switch_output  (sw),
        .stall          (st),
        .top_tuple      (tt),
        .i_elems_0      (a),
        .i_elems_1      (b),
        .o_elems_0      (o0),
        .o_elems_1      (o1),
        .o_switch_output(osw),
        .o_stall        (ost),
        .o_top_tuple    (ott)
    );

    function automatic elem_t mk(input logic [KW-1:0] k, input logic [DW-KW-1:0] p);
        return {p, k};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    task automatic ref_merge(input blk_t ra, input blk_t rb, output blk_t lo, output blk_t hi);
        elem_t v[16];
        elem_t t;
        int j;
        for (int i = 0; i < 8; i++) begin
            v[i]   = elem_at(ra, i);
            v[8+i] = elem_at(rb, i);
        end
        for (int i = 1; i < 16; i++) begin
            t = v[i];
            j = i;
            while (j > 0 && key_of(v[j-1]) > key_of(t)) begin
                v[j] = v[j-1];
                j--;
            end
            v[j] = t;
        end
        for (int i = 0; i < 8; i++) begin
            lo[i*DW +: DW] = v[i];
            hi[i*DW +: DW] = v[8+i];
        end
    endtask

    task automatic mark(input elem_t x, inout logic [15:0] seen);
        logic [DW-KW-1:0] p;
        p = x[DW-1:KW];
        if (p >= 'hA0 && p <= 'hA7) seen[int'(p - 'hA0)] = 1'b1;
        if (p >= 'hB0 && p <= 'hB7) seen[8 + int'(p - 'hB0)] = 1'b1;
    endtask

    task automatic compare(input exp_t e);
        logic [15:0] seen;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            if (e.tie) begin
                check($sformatf("tie_key_lo%0d", i), DW'(key_of(elem_at(o0, i))), DW'(5));
                check($sformatf("tie_key_hi%0d", i), DW'(key_of(elem_at(o1, i))), DW'(5));
                mark(elem_at(o0, i), seen);
                mark(elem_at(o1, i), seen);
            end else begin
                check($sformatf("lo%0d", i), elem_at(o0, i), elem_at(e.e0, i));
                check($sformatf("hi%0d", i), elem_at(o1, i), elem_at(e.e1, i));
            end
            check($sformatf("tt%0d", i), elem_at(ott, i), elem_at(e.tt, i));
        end
        if (e.tie) check("tie_payloads", DW'(seen), DW'(16'hFFFF));
        check("switch", DW'(osw), DW'(e.sw));
        check("stall", DW'(ost), DW'(e.st));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) compare(sb.pop_front());
    endtask

    task automatic beat(input blk_t na, input blk_t nb, input blk_t ntt, input logic nsw, input logic nst, input logic ntie);
        exp_t e;
        blk_t lo, hi;
        a  = na;
        b  = nb;
        tt = ntt;
        sw = nsw;
        st = nst;
        ref_merge(na, nb, lo, hi);
        e.e0  = lo;
        e.e1  = hi;
        e.tt  = ntt;
        e.sw  = nsw;
        e.st  = nst;
        e.tie = ntie;
        e.due = cyc + LATENCY;
        sb.push_back(e);
        tick();
    endtask

    task automatic do_reset();
        exp_t e;
        rst = 1'b1;
        a   = {32{$urandom}};
        b   = {32{$urandom}};
        tt  = {32{$urandom}};
        sw  = 1'b1;
        st  = 1'b0;
        sb.delete();
        e.e0  = '0;
        e.e1  = '0;
        e.tt  = '0;
        e.sw  = 1'b0;
        e.st  = 1'b1;
        e.tie = 1'b0;
        for (int k = 1; k <= LATENCY; k++) begin
            e.due = cyc + k;
            sb.push_back(e);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_pair(output blk_t ra, output blk_t rb);
        int   idx[16];
        logic in_a[16];
        int   ia, ib, r, t;
        elem_t e;
        ra = '0;
        rb = '0;
        for (int j = 0; j < 16; j++) begin
            idx[j]  = j;
            in_a[j] = 1'b0;
        end
        for (int j = 15; j > 0; j--) begin
            r      = int'($urandom_range(0, j));
            t      = idx[j];
            idx[j] = idx[r];
            idx[r] = t;
        end
        for (int j = 0; j < 8; j++) in_a[idx[j]] = 1'b1;
        ia = 0;
        ib = 0;
        for (int j = 0; j < 16; j++) begin
            e = mk({16'(j), $urandom, $urandom}, 48'({$urandom, $urandom}));
            if (in_a[j]) begin
                ra[ia*DW +: DW] = e;
                ia++;
            end else begin
                rb[ib*DW +: DW] = e;
                ib++;
            end
        end
    endtask

    initial begin
        blk_t ta, tb2, ttt;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ta[i*DW +: DW]  = mk(KW'(2*i + 1), '0);
            tb2[i*DW +: DW] = mk(KW'(2*i + 2), '0);
        end
        beat(ta, tb2, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ta[i*DW +: DW]  = mk(KW'(i + 9), '0);
            tb2[i*DW +: DW] = mk(KW'(i + 1), '0);
        end
        beat(ta, tb2, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ta[i*DW +: DW]  = mk(KW'(5), 48'hA0 + 48'(i));
            tb2[i*DW +: DW] = mk(KW'(5), 48'hB0 + 48'(i));
        end
        beat(ta, tb2, '0, 1'b0, 1'b0, 1'b1);
        rand_pair(ta, tb2);
        beat(ta, tb2, {64{16'hDEAD}}, 1'b0, 1'b0, 1'b0);
        beat('0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 20; n++) begin
            rand_pair(ta, tb2);
            ttt = {32{$urandom}};
            beat(ta, tb2, ttt, 1'($urandom_range(0, 1)), 1'(n % 2), 1'b0);
        end
        for (int n = 0; n < 3; n++) begin
            rand_pair(ta, tb2);
            beat(ta, tb2, {32{$urandom}}, 1'b1, 1'b0, 1'b0);
        end
        do_reset();
        for (int n = 0; n < 6; n++) begin
            rand_pair(ta, tb2);
            beat(ta, tb2, {32{$urandom}}, 1'(n % 2), 1'(n == 3), 1'b0);
        end
        for (int n = 0; n < LATENCY; n++) beat('0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 2 * LATENCY && sb.size() > 0; n++) tick();
        if (sb.size() > 0) check("drain", DW'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
